// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Handshake, instruction and datapath-control bundle between a
//            host and the alu_op_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
);
    logic                start;
    logic                mem_ready;
    logic [DATA_W-1:0]   ir;
    logic                PCout, Zlowout, Zhighout, MDRout;
    logic                MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin;
    logic                HIin, LOin, IncPC, Read;
    logic [NUM_REGS-1:0] reg_out_sel;
    logic [NUM_REGS-1:0] reg_in_sel;
    logic [OPC_W-1:0]    alu_op;
    logic                busy, done, illegal;

    modport master (
        output start, mem_ready, ir,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin,
        input  HIin, LOin, IncPC, Read,
        input  reg_out_sel, reg_in_sel, alu_op, busy, done, illegal
    );

    modport slave (
        input  start, mem_ready, ir,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin,
        output HIin, LOin, IncPC, Read,
        output reg_out_sel, reg_in_sel, alu_op, busy, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Fetch/execute control FSM for the Mini-SRC datapath; runs one
//            three-register ALU instruction per start. SEQ_MULDIV_EN adds
//            the MUL/DIV HI/LO path (state T6).
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  wire logic         clock,
    input  wire logic         clear,
    alu_op_sequencer_if.slave bus
);
    localparam int REG_W   = $clog2(NUM_REGS);
    localparam int FLD_LSB = DATA_W - OPC_W - 3*REG_W;

    localparam logic [OPC_W-1:0] C_OP_SUB = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] C_OP_ADD = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] C_OP_AND = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] C_OP_OR  = OPC_W'(5'b00110);
`ifdef SEQ_MULDIV_EN
    localparam logic [OPC_W-1:0] C_OP_MUL = OPC_W'(5'b01111);
    localparam logic [OPC_W-1:0] C_OP_DIV = OPC_W'(5'b10000);
`endif

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T2X  = 4'd7
`ifdef SEQ_MULDIV_EN
        , S_T6 = 4'd8
`endif
    } state_t;

    state_t r_state;

    logic [OPC_W-1:0] w_opcode;
    logic [REG_W-1:0] w_ra, w_rb, w_rc;
    logic             w_is_alu3, w_is_muldiv, w_legal;

    assign w_opcode = bus.ir[DATA_W-1 -: OPC_W];
    assign w_ra     = bus.ir[DATA_W-OPC_W-1 -: REG_W];
    assign w_rb     = bus.ir[DATA_W-OPC_W-REG_W-1 -: REG_W];
    assign w_rc     = bus.ir[DATA_W-OPC_W-2*REG_W-1 -: REG_W];

    generate
        if (FLD_LSB > 0) begin : g_ir_spare
            logic w_unused_ir;
            assign w_unused_ir = ^bus.ir[FLD_LSB-1:0];
        end
    endgenerate

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // MUL/DIV leave ra unused, so only rb/rc are range-checked for them
    always_comb begin
        w_is_alu3 = (w_opcode == C_OP_SUB) || (w_opcode == C_OP_ADD) ||
                    (w_opcode == C_OP_AND) || (w_opcode == C_OP_OR);
`ifdef SEQ_MULDIV_EN
        w_is_muldiv = (w_opcode == C_OP_MUL) || (w_opcode == C_OP_DIV);
`else
        w_is_muldiv = 1'b0;
`endif
        w_legal = ((w_is_alu3 && (int'(w_ra) < NUM_REGS)) || w_is_muldiv) &&
                  (int'(w_rb) < NUM_REGS) && (int'(w_rc) < NUM_REGS);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   if (bus.mem_ready) r_state <= S_T2;
                S_T2:   r_state <= S_T3;
                S_T3:   r_state <= w_legal ? S_T4 : S_T2X;
                S_T4:   r_state <= S_T5;
`ifdef SEQ_MULDIV_EN
                S_T5:   r_state <= w_is_muldiv ? S_T6 : S_IDLE;
                S_T6:   r_state <= S_IDLE;
`else
                S_T5:   r_state <= S_IDLE;
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.PCout       = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.MDRout      = 1'b0;
        bus.MARin       = 1'b0;
        bus.PCin        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zlowin      = 1'b0;
        bus.IncPC       = 1'b0;
        bus.Read        = 1'b0;
        bus.reg_out_sel = '0;
        bus.reg_in_sel  = '0;
        bus.alu_op      = '0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
`ifdef SEQ_MULDIV_EN
        bus.Zhighout    = 1'b0;
        bus.Zhighin     = 1'b0;
        bus.HIin        = 1'b0;
        bus.LOin        = 1'b0;
`endif
        bus.busy        = (r_state != S_IDLE);
        case (r_state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (w_legal) begin
                    bus.reg_out_sel = onehot(w_rb);
                    bus.Yin         = 1'b1;
                end
            end
            S_T4: begin
                bus.reg_out_sel = onehot(w_rc);
                bus.alu_op      = w_opcode;
                bus.Zlowin      = 1'b1;
`ifdef SEQ_MULDIV_EN
                bus.Zhighin     = w_is_muldiv;
`endif
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
`ifdef SEQ_MULDIV_EN
                if (w_is_muldiv) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.reg_in_sel = onehot(w_ra);
                    bus.done       = 1'b1;
                end
`else
                bus.reg_in_sel = onehot(w_ra);
                bus.done       = 1'b1;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
            end
`endif
            S_T2X:   bus.illegal = 1'b1;
            default: ;
        endcase
    end

`ifndef SEQ_MULDIV_EN
    assign bus.Zhighout = 1'b0;
    assign bus.Zhighin  = 1'b0;
    assign bus.HIin     = 1'b0;
    assign bus.LOin     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Scoreboard bench for alu_op_sequencer; expected sequence results
//            are queued at start and compared when done/illegal fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
    logic clock;
    logic clear;

    alu_op_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5)) bus ();

    alu_op_sequencer #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          end_cyc;
        bit          is_illegal;
        logic [15:0] ros3;
        logic [15:0] ros4;
        logic [4:0]  alu4;
        logic [15:0] wr;
        logic [3:0]  hilo;
        int          reads;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int ec, input bit ill, input logic [15:0] r3,
                                input logic [15:0] r4, input logic [4:0] a,
                                input logic [15:0] w, input logic [3:0] h, input int rd);
        exp_t e;
        e.end_cyc = ec; e.is_illegal = ill; e.ros3 = r3; e.ros4 = r4;
        e.alu4 = a; e.wr = w; e.hilo = h; e.reads = rd;
        return e;
    endfunction

    function automatic logic [17:0] ctrl_vec();
        return {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.MARin, bus.PCin,
                bus.MDRin, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin, bus.HIin,
                bus.LOin, bus.IncPC, bus.Read, bus.busy, bus.done, bus.illegal};
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctrl"}, 32'(ctrl_vec()), 32'h0);
        check_val({tag, "_sel"},  {bus.reg_out_sel, bus.reg_in_sel}, 32'h0);
        check_val({tag, "_alu"},  32'(bus.alu_op), 32'h0);
    endtask

    task automatic run_seq(input string name, input logic [31:0] instr, input int waits,
                           input bit extra, input exp_t e);
        exp_t        x;
        int          c, end_c, reads, stray, multi, drv, not_busy, idle_busy;
        bit          fin, got_ill;
        logic [15:0] ros3, ros4, wr;
        logic [4:0]  alu4;
        logic [3:0]  hilo;
        sb.push_back(e);
        c = 0; fin = 0; end_c = 0; got_ill = 0; reads = 0; stray = 0; multi = 0;
        not_busy = 0; idle_busy = 0;
        ros3 = '0; ros4 = '0; wr = '0; alu4 = '0; hilo = '0;
        @(posedge clock); #1;
        bus.ir = instr; bus.start = 1'b1; bus.mem_ready = 1'b1;
        while (!fin && c < 40) begin
            @(posedge clock); #1;
            c++;
            bus.start     = extra && (c == 3 || c == e.end_cyc);
            bus.mem_ready = !(c >= 2 && c < 2 + waits);
            @(negedge clock);
            reads += int'(bus.Read);
            wr    |= bus.reg_in_sel;
            hilo  |= {bus.HIin, bus.LOin, bus.Zhighin, bus.Zhighout};
            if (!bus.busy) not_busy++;
            if (c == 4 + waits) ros3 = bus.reg_out_sel;
            if (c == 5 + waits) begin
                ros4 = bus.reg_out_sel;
                alu4 = bus.alu_op;
            end else if (bus.alu_op != 0) begin
                stray++;
            end
            drv = int'(bus.PCout) + int'(bus.Zlowout) + int'(bus.Zhighout) +
                  int'(bus.MDRout) + $countones(bus.reg_out_sel);
            if (drv > 1) multi++;
            if (bus.done || bus.illegal) begin
                fin = 1; end_c = c; got_ill = bus.illegal;
            end
        end
        bus.start = 1'b0;
        check_val({name, "_finished"}, 32'(fin), 32'h1);
        x = sb.pop_front();
        check_val({name, "_end_cycle"}, end_c, x.end_cyc);
        check_val({name, "_illegal"}, 32'(got_ill), 32'(x.is_illegal));
        check_val({name, "_T3_reg_out"}, 32'(ros3), 32'(x.ros3));
        check_val({name, "_T4_reg_out"}, 32'(ros4), 32'(x.ros4));
        check_val({name, "_T4_alu_op"}, 32'(alu4), 32'(x.alu4));
        check_val({name, "_reg_in_sel"}, 32'(wr), 32'(x.wr));
        check_val({name, "_hilo_zhigh"}, 32'(hilo), 32'(x.hilo));
        check_val({name, "_read_cycles"}, reads, x.reads);
        check_val({name, "_stray_alu_op"}, stray, 0);
        check_val({name, "_multi_driver"}, multi, 0);
        check_val({name, "_busy_gap"}, not_busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            if (bus.busy) idle_busy++;
        end
        check_val({name, "_idle_after"}, idle_busy, 0);
    endtask

    initial begin
        exp_t e_mul;
        clear = 1'b1;
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_quiet("reset");
        @(posedge clock); #1;
        clear = 1'b0;

        run_seq("sub", 32'h1891_8000, 0, 1'b0, mk(6, 0, 16'h4, 16'h8, 5'h03, 16'h2, 4'h0, 1));
        run_seq("and_wait", 32'h2891_8000, 3, 1'b0, mk(9, 0, 16'h4, 16'h8, 5'h05, 16'h2, 4'h0, 4));
`ifdef SEQ_MULDIV_EN
        e_mul = mk(7, 0, 16'h4, 16'h8, 5'h0F, 16'h0, 4'hF, 1);
`else
        e_mul = mk(5, 1, 16'h0, 16'h0, 5'h00, 16'h0, 4'h0, 1);
`endif
        run_seq("mul", 32'h7811_8000, 0, 1'b0, e_mul);
        run_seq("illegal_op", 32'hF800_0000, 0, 1'b0, mk(5, 1, 16'h0, 16'h0, 5'h00, 16'h0, 4'h0, 1));

        // Abort a SUB in T4 with an asynchronous clear between clock edges
        @(posedge clock); #1;
        bus.ir = 32'h1891_8000; bus.start = 1'b1; bus.mem_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
        end
        #1;
        check_val("mid_T4_alu_op", 32'(bus.alu_op), 32'h3);
        clear = 1'b1;
        #1;
        check_quiet("clear_mid_op");
        @(negedge clock);
        check_quiet("clear_held");
        @(posedge clock); #1;
        clear = 1'b0;
        run_seq("sub_after_clear", 32'h1891_8000, 0, 1'b0, mk(6, 0, 16'h4, 16'h8, 5'h03, 16'h2, 4'h0, 1));

        run_seq("add_start_busy", 32'h2091_8000, 0, 1'b1, mk(6, 0, 16'h4, 16'h8, 5'h04, 16'h2, 4'h0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer for the Mini-SRC datapath. It fetches one instruction and executes it as a three-register ALU operation. It replaces hand-driven T0–T5 control strobes with a parametrised FSM that decodes the opcode and register fields from the IR and supports memory wait states. It sits beside `Datapath` and drives that block's bus-select, register-enable and ALU opcode inputs directly.

## Interface
Parameters:
- `DATA_W`, 32, instruction/datapath width
- `NUM_REGS`, 16, general registers addressed; field width `REG_W = $clog2(NUM_REGS)`
- `OPC_W`, 5, opcode field width, located at `ir[DATA_W-1 -: OPC_W]`

Ports:
- `clock`  in  1  system clock, rising edge
- `clear`  in  1  asynchronous active-high reset
- `start`  in  1  begin one fetch/execute sequence; sampled in IDLE only
- `mem_ready`  in  1  memory read data valid this cycle
- `ir`  in  DATA_W  instruction register contents; valid from T3 on
- `PCout, Zlowout, Zhighout, MDRout`  out  1 each  bus drivers
- `MARin, PCin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, IncPC, Read`  out  1 each  load enables and control
- `reg_out_sel`  out  NUM_REGS  one-hot register bus driver
- `reg_in_sel`  out  NUM_REGS  one-hot register load enable
- `alu_op`  out  OPC_W  opcode to the ALU
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in the final execute state
- `illegal`  out  1  one-cycle pulse in T2X (undecodable instruction)

## Operation
- Field decode: `ra = ir[DATA_W-OPC_W-1 -: REG_W]`, `rb` is the next REG_W bits below `ra`, `rc` is the next REG_W bits below `rb`.
- Supported opcodes: 00011 SUB, 00100 ADD, 00101 AND, 00110 OR, 01111 MUL, 10000 DIV (MUL and DIV are macro-gated).
- States are IDLE, T0, T1, T2, T3, T4, T5, T6 and T2X. Outputs are Moore, decoded from the state register plus the `ir` fields.
- IDLE: all outputs 0. `start` = 1 → T0.
- T0: PCout, MARin, IncPC, Zlowin (PC+1 is latched into Z) → T1.
- T1: Zlowout, PCin, Read, MDRin asserted.
  - `mem_ready` = 0: hold T1 with outputs unchanged.
  - `mem_ready` = 1: → T2.
- T2: MDRout, IRin → T3.
- T3: legality is checked here.
  - Illegal if the opcode is unsupported, or if any used field ≥ NUM_REGS (`ra` is not used by MUL/DIV). Illegal → T2X, with no outputs asserted in that cycle.
  - Otherwise assert `reg_out_sel[rb]` and Yin → T4.
- T4: `reg_out_sel[rc]`, `alu_op = opcode`, Zlowin. For MUL/DIV, Zhighin is also asserted → T5.
- T5:
  - SUB/ADD/AND/OR: Zlowout, `reg_in_sel[ra]`, `done` → IDLE.
  - MUL/DIV: Zlowout, LOin → T6.
- T6: Zhighout, HIin, `done` → IDLE.
- T2X: `illegal` pulse → IDLE. No register or HI/LO write occurs.
- `alu_op` is 0 in every state except T4.
- At most one bus driver is asserted in any cycle.

## Timing
- `clear` asserted → IDLE immediately (asynchronous); every output is 0 while `clear` is high, including mid-sequence. No partial write completes.
- `start` sampled high at posedge in IDLE → T0 on that edge.
- With `mem_ready` already high in T1, `done` is asserted in cycle 6 after the start edge for a 3-register op, and in cycle 7 for MUL/DIV.
- Each cycle `mem_ready` is low in T1 adds one cycle of latency.
- `start` while busy is ignored (no queuing). `start` in the same cycle `done` is asserted is also ignored; the next sequence needs `start` sampled in IDLE.
- `ir` is sampled combinationally from T3 through T6 and must remain stable over that window.

## Configuration
- `SEQ_MULDIV_EN` defined: MUL (01111) and DIV (10000) are legal and use the T5→T6 HI/LO path; T6 exists.
- `SEQ_MULDIV_EN` undefined: both opcodes decode as illegal → T2X. T6 and the HIin/LOin/Zhighin/Zhighout assertion logic are compiled out, and those outputs are tied to 0.

## Test plan
- SUB: `ir` = 0x18918000, `mem_ready` = 1 → T3 `reg_out_sel` = 0x0004; T4 `reg_out_sel` = 0x0008 with `alu_op` = 00011; T5 `reg_in_sel` = 0x0002 with `done`; total 6 cycles.
- Memory wait: AND with `ir` = 0x28918000, `mem_ready` low for 3 cycles in T1 → Read and MDRin held 4 cycles; `done` at cycle 9; `alu_op` = 00101.
- MUL (macro defined): `ir` = 0x78118000 → T5 asserts LOin and Zlowout; T6 asserts HIin, Zhighout and `done`; `reg_in_sel` stays 0 throughout. With the macro undefined, the same instruction gives an `illegal` pulse and no writes.
- Illegal opcode: `ir` = 0xF8000000 → `illegal` pulse 4 cycles after start, → IDLE, and no `reg_in_sel`/HIin/LOin activity.
- Reset mid-op: assert `clear` during T4 → all outputs 0 within the same cycle, `busy` = 0; after release, a new `start` runs a clean 6-cycle sequence.
- Start while busy: pulse `start` during T2 and again in the `done` cycle → exactly one sequence runs, and `busy` drops after `done`.
